// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the LEGv8 iterative multiply/divide unit.
//   WIDTH    operand/result width (64 only)
//   ITER     iterations per operation
//   OP_*     operation encodings on the 3-bit op bus
//   state_e  control FSM states
// Macro MULDIV_DIV_EN: when defined, SDIV/UDIV are legal operations.
package muldiv_pkg;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned ITER  = 64;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_SMULH = 3'b001;
  localparam logic [2:0] OP_UMULH = 3'b010;
  localparam logic [2:0] OP_SDIV  = 3'b100;
  localparam logic [2:0] OP_UDIV  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_MUL, OP_SMULH, OP_UMULH: return 1'b1;
`ifdef MULDIV_DIV_EN
      OP_SDIV, OP_UDIV:           return 1'b1;
`endif
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    return (op == OP_SMULH) || (op == OP_SDIV);
  endfunction

endpackage

// File: rtl/cond_neg.sv
// cond_neg: conditional two's-complement negation.
//   x_i    operand
//   neg_i  1 = negate (invert and add inc_i), 0 = pass through
//   inc_i  carry-in of the negation; 0 lets the caller negate the upper
//          half of a wider value whose lower half is non-zero
//   y_o    result
module cond_neg
  import muldiv_pkg::*;
(
  input  logic [WIDTH-1:0] x_i,
  input  logic             neg_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb y_o = neg_i ? (~x_i + WIDTH'(inc_i)) : x_i;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 64-bit MUL/SMULH/UMULH/SDIV/UDIV for the LEGv8
// datapath. 66-cycle latency; result and rd_out held after the done pulse.
//   clk, rst_n       clock, asynchronous active-low reset
//   start, op        request (sampled in IDLE) and operation code
//   abort            synchronous cancel, no done pulse
//   op_a, op_b       Rn / Rm operand values
//   rd_in            destination register index
//   busy             high while not IDLE (stalls the PC)
//   done             one-cycle result-valid pulse
//   result, rd_out   registered result and destination index
//   illegal          pulses with done for illegal or compiled-out ops
// Macro MULDIV_DIV_EN: when defined the restoring divider is built;
// otherwise SDIV/UDIV complete as illegal ops.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out,
  output logic             illegal
);

  state_e             state_q, state_d;
  logic [2:0]         op_q;
  logic [4:0]         rd_q, rd_out_q;
  logic [WIDTH-1:0]   a_q, b_q, result_q;
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [6:0]         cnt_q;
  logic               sign_q, ill_q, done_q, illegal_q;
`ifdef MULDIV_DIV_EN
  logic               dz_q;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               qbit;
`endif

  logic               sgn_a, sgn_b, fix_inc;
  logic [WIDTH-1:0]   abs_a, abs_b, fix_in, fix_out, res_fix;
  logic [WIDTH:0]     mul_sum;

  assign sgn_a = op_signed(op) & op_a[WIDTH-1];
  assign sgn_b = op_signed(op) & op_b[WIDTH-1];

  cond_neg u_abs_a (.x_i(op_a), .neg_i(sgn_a), .inc_i(1'b1), .y_o(abs_a));
  cond_neg u_abs_b (.x_i(op_b), .neg_i(sgn_b), .inc_i(1'b1), .y_o(abs_b));

  // Multiply: right-shifting shift-add, product bits fall into the low half.
  // Divide: restoring; remainder in the high half, quotient shifts into the
  // low half while dividend bits are fed from the top of a_q.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
    acc_step = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    qbit     = (rem_sh >= {1'b0, b_q});
    rem_sub  = qbit ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
    if (op_q[2]) acc_step = {rem_sub, acc_q[WIDTH-2:0], qbit};
`endif
  end

  // High-half negation of a 128-bit product only takes the +1 carry when
  // the low half is all zeros.
  assign fix_in  = (op_q == OP_MUL || op_q[2]) ? acc_q[WIDTH-1:0]
                                               : acc_q[2*WIDTH-1:WIDTH];
  assign fix_inc = op_q[2] | (acc_q[WIDTH-1:0] == '0);

  cond_neg u_fix (.x_i(fix_in), .neg_i(sign_q), .inc_i(fix_inc), .y_o(fix_out));

  always_comb begin
    res_fix = fix_out;
`ifdef MULDIV_DIV_EN
    if (op_q[2] && dz_q) res_fix = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_d = op_legal(op) ? S_RUN : S_DONE;
        S_RUN:  if (cnt_q == 7'(ITER - 1)) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rd_out_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      ill_q     <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      if (!abort) begin
        case (state_q)
          S_IDLE: if (start) begin
            op_q   <= op;
            rd_q   <= rd_in;
            a_q    <= abs_a;
            b_q    <= abs_b;
            sign_q <= sgn_a ^ sgn_b;
            acc_q  <= '0;
            cnt_q  <= '0;
            ill_q  <= !op_legal(op);
`ifdef MULDIV_DIV_EN
            dz_q   <= (op_b == '0);
`endif
            if (!op_legal(op)) begin
              result_q <= '0;
              rd_out_q <= rd_in;
            end
          end
          S_RUN: begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 7'd1;
            if (op_q[2]) a_q <= a_q << 1;
            else         b_q <= b_q >> 1;
          end
          S_FIX: begin
            result_q <= res_fix;
            rd_out_q <= rd_q;
          end
          S_DONE: begin
            done_q    <= 1'b1;
            illegal_q <= ill_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign result  = result_q;
  assign rd_out  = rd_out_q;
  assign illegal = illegal_q;

endmodule
